// File: rtl/shift_sequencer_if.sv
// Operand, control and status bundle for shift_sequencer.
// Valid/ready: start is a request that is taken on a rising edge only while busy=0; no ready is returned.
interface shift_sequencer_if;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  modport master (
    output start, flush, op, data_in, shamt,
    input  busy, done, result, state_dbg
  );

  modport slave (
    input  start, flush, op, data_in, shamt,
    output busy, done, result, state_dbg
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit barrel-shift replacement: shifts up to two bit positions per clock
// until the captured shift amount is used up, then pulses done for one cycle.
module shift_sequencer (
  input  logic             clock,
  input  logic             reset_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] result_q, result_nx;
  logic [4:0]  rem_q, rem_nx;
  logic [1:0]  op_q, op_nx;
  logic        two_step;
  logic [4:0]  step_amt;
  logic [31:0] step_val;

  // One shift step of the working value; SRA replicates the current sign bit.
  always_comb begin
    two_step = (rem_q >= 5'd2);
    step_amt = two_step ? 5'd2 : 5'd1;
    case (op_q)
      2'b00:   step_val = two_step ? {result_q[29:0], 2'b00}
                                   : {result_q[30:0], 1'b0};
      2'b01:   step_val = two_step ? {{2{result_q[31]}}, result_q[31:2]}
                                   : {result_q[31], result_q[31:1]};
      default: step_val = two_step ? {2'b00, result_q[31:2]}
                                   : {1'b0, result_q[31:1]};
    endcase
  end

  always_comb begin
    state_nx  = state;
    result_nx = result_q;
    rem_nx    = rem_q;
    op_nx     = op_q;
    case (state)
      IDLE, DONE: begin
        // flush outranks start and leaves the held result alone.
        if (bus.flush) begin
          state_nx = IDLE;
        end else if (bus.start) begin
          result_nx = bus.data_in;
          op_nx     = bus.op;
          rem_nx    = bus.shamt;
          state_nx  = (bus.shamt == 5'd0) ? DONE : SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (bus.flush) begin
          state_nx = IDLE;
        end else begin
          result_nx = step_val;
          rem_nx    = rem_q - step_amt;
          state_nx  = (rem_nx == 5'd0) ? DONE : SHIFT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      result_q <= 32'd0;
      rem_q    <= 5'd0;
      op_q     <= 2'b00;
    end else begin
      state    <= state_nx;
      result_q <= result_nx;
      rem_q    <= rem_nx;
      op_q     <= op_nx;
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: cycle-level reference model, directed vectors
// with literal expectations, and a randomized phase.
module tb_shift_sequencer;

  logic clock;
  logic reset_n;
  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: operation-level view, final value from native shift operators
  int          m_left;
  int          m_steps;
  int          m_sh;
  logic        m_done;
  logic        m_known;
  logic [31:0] m_res;
  logic [31:0] m_data;
  logic [1:0]  m_op;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int amt);
    case (op)
      2'b00:   return d << amt;
      2'b01:   return $signed(d) >>> amt;
      default: return d >> amt;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_steps = 0; m_sh = 0; m_done = 1'b0;
      m_known = 1'b1; m_res = 32'd0; m_data = 32'd0; m_op = 2'b00;
    end else if (m_left > 0) begin
      if (bus.flush) begin
        m_left  = 0;
        m_done  = 1'b0;
        m_res   = ref_shift(m_op, m_data, (2 * m_steps < m_sh) ? 2 * m_steps : m_sh);
        m_known = 1'b1;
      end else begin
        m_steps++;
        m_left--;
        if (m_left == 0) begin
          m_done  = 1'b1;
          m_res   = ref_shift(m_op, m_data, m_sh);
          m_known = 1'b1;
        end
      end
    end else if (bus.flush) begin
      m_done = 1'b0;
    end else if (bus.start) begin
      m_op = bus.op; m_data = bus.data_in; m_sh = int'(bus.shamt); m_steps = 0;
      if (bus.shamt == 5'd0) begin
        m_done = 1'b1; m_res = bus.data_in; m_known = 1'b1;
      end else begin
        m_left = (m_sh + 1) / 2; m_done = 1'b0; m_known = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // scoreboard compare, every falling edge
  always @(negedge clock) begin
    chk("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
    chk("done", {31'd0, bus.done}, {31'd0, m_done});
    if (m_known) chk("result", bus.result, m_res);
    if (bus.busy) busy_cnt++;
  end

  // driver tasks (called just after a falling edge)
  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    bus.start = 1'b1; bus.op = op; bus.data_in = d; bus.shamt = sh;
    busy_cnt = 0;
    @(negedge clock);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.data_in = $urandom; bus.shamt = 5'($urandom);
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_res, input int exp_busy);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end else begin
      chk({name, "_result"}, bus.result, exp_res);
      chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.data_in = 32'd0; bus.shamt = 5'd0;
    #3;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // SRA sign fill, odd amount
    issue(2'b01, 32'h80000000, 5'd5);
    wait_done("sra5", 32'hFC000000, 3);
    @(negedge clock);

    // SLL max amount, with starts during SHIFT that must be ignored
    issue(2'b00, 32'h00000001, 5'd31);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.data_in = 32'hDEADBEEF; bus.shamt = 5'd7; bus.op = 2'b10;
      @(negedge clock);
    end
    bus.start = 1'b0;
    wait_done("sll31", 32'h80000000, 16);
    @(negedge clock);

    issue(2'b10, 32'hF0000000, 5'd4);
    wait_done("srl4", 32'h0F000000, 2);
    // back-to-back: new start in the done cycle
    issue(2'b01, 32'h00000080, 5'd3);
    wait_done("b2b_sra3", 32'h00000010, 2);
    @(negedge clock);

    // zero shift amount
    issue(2'b11, 32'h12345678, 5'd0);
    wait_done("sh0", 32'h12345678, 0);
    @(negedge clock);

    // flush at the second shift edge
    issue(2'b00, 32'h000000FF, 5'd9);
    @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    chk("flush_partial", bus.result, 32'h000003FC);
    repeat (12) @(negedge clock);

    // asynchronous reset mid-operation
    issue(2'b00, 32'hA5A5A5A5, 5'd20);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_result", bus.result, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);

    // randomized phase; the model checks every cycle
    for (int i = 0; i < 600; i++) begin
      int r;
      bus.start = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.op = 2'($urandom);
      bus.data_in = $urandom;
      r = $urandom_range(0, 9);
      bus.shamt = (r == 0) ? 5'd0 : (r == 1) ? 5'd1 : (r == 2) ? 5'd31 : 5'($urandom_range(0, 31));
      @(negedge clock);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (20) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
